// File: rtl/tiny_nn_pkg.sv
// Shared types and command opcodes for the tiny NN convolution sequencer.
// Pure declarations: no logic, no latency, no flow control.
package tiny_nn_pkg;

    typedef logic [15:0] fp_t;

    localparam logic [3:0] CmdOpConvolve       = 4'h1;
    localparam logic [3:0] CmdOpConvolveCached = 4'h2;

endpackage

// File: rtl/tiny_nn_param_cache.sv
// Parameter store replayed by cached convolutions; one-cycle write, combinational read.
// No backpressure; contents are unreset and only trusted under the sequencer's valid flag.
module tiny_nn_param_cache
    import tiny_nn_pkg::*;
#(
    parameter int Depth = 8,
    parameter int IdxW  = $clog2(Depth)
) (
    input  logic            clk_i,
    input  logic            we_i,
    input  logic [IdxW-1:0] waddr_i,
    input  fp_t             wdata_i,
    input  logic [IdxW-1:0] raddr_i,
    output fp_t             rdata_o
);

    fp_t mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/tiny_nn_conv_seq.sv
// Host-word sequencer: decodes commands, loads or replays 8 core parameters, then runs 2*(count+1) exec cycles.
// Command at cycle N gives parameters on N+1..N+8 and Exec from N+9; no backpressure, one host word per cycle.
module tiny_nn_conv_seq
    import tiny_nn_pkg::*;
#(
    parameter int ValArrayWidth  = 4,
    parameter int ValArrayHeight = 2,
    parameter int CountWidth     = 12
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [15:0]                           data_i,
    output logic [7:0]                            data_o,
    output fp_t                                   core_val_o,
    output logic [ValArrayHeight-1:0]             core_val_shift_o,
    output fp_t                                   core_param_o,
    output logic [ValArrayWidth*ValArrayHeight-1:0] core_param_write_o,
    output logic                                  core_mul_row_sel_o,
    output logic                                  core_mul_en_o,
    output logic [1:0]                            core_accumulate_en_o,
    input  fp_t                                   core_accumulate_i
);

    localparam int NumParams = ValArrayWidth * ValArrayHeight;
    localparam int IdxW      = $clog2(NumParams);

    typedef enum logic [1:0] {Idle, ParamIn, ParamReplay, Exec} state_e;

    state_e                state_q, state_d;
    logic [CountWidth-1:0] count_q, count_d;
    logic [IdxW-1:0]       index_q, index_d;
    logic                  phase_q, phase_d;
    logic                  cache_valid_q, cache_valid_d;

    logic                  cache_we;
    fp_t                   cache_rdata;
    logic                  last_param;

    assign last_param = (index_q == IdxW'(NumParams - 1));
    assign core_val_o = data_i;

    tiny_nn_param_cache #(
        .Depth (NumParams)
    ) u_param_cache (
        .clk_i   (clk_i),
        .we_i    (cache_we),
        .waddr_i (index_q),
        .wdata_i (data_i),
        .raddr_i (index_q),
        .rdata_o (cache_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= Idle;
            count_q       <= '0;
            index_q       <= '0;
            phase_q       <= 1'b0;
            cache_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            index_q       <= index_d;
            phase_q       <= phase_d;
            cache_valid_q <= cache_valid_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        index_d       = index_q;
        phase_d       = phase_q;
        cache_valid_d = cache_valid_q;
        unique case (state_q)
            Idle: begin
                if (data_i[15:12] == CmdOpConvolve) begin
                    count_d       = CountWidth'(data_i[11:0]);
                    cache_valid_d = 1'b0;
                    index_d       = '0;
                    state_d       = ParamIn;
                end else if (data_i[15:12] == CmdOpConvolveCached && cache_valid_q) begin
                    count_d = CountWidth'(data_i[11:0]);
                    index_d = '0;
                    state_d = ParamReplay;
                end
            end
            ParamIn, ParamReplay: begin
                index_d = index_q + 1'b1;
                if (last_param) begin
                    // Only a completed fresh load makes the cache trustworthy again.
                    if (state_q == ParamIn) begin
                        cache_valid_d = 1'b1;
                    end
                    phase_d = 1'b0;
                    state_d = Exec;
                end
            end
            Exec: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    if (count_q != '0) begin
                        count_d = count_q - 1'b1;
                    end else begin
                        state_d = Idle;
                    end
                end
            end
            default: state_d = Idle;
        endcase
    end

    always_comb begin
        data_o               = 8'hFF;
        core_val_shift_o     = '0;
        core_param_o         = data_i;
        core_param_write_o   = '0;
        core_mul_row_sel_o   = 1'b0;
        core_mul_en_o        = 1'b0;
        core_accumulate_en_o = '0;
        cache_we             = 1'b0;
        unique case (state_q)
            ParamIn: begin
                core_param_write_o = NumParams'(1) << index_q;
                cache_we           = 1'b1;
            end
            ParamReplay: begin
                core_param_o       = cache_rdata;
                core_param_write_o = NumParams'(1) << index_q;
            end
            Exec: begin
                core_val_shift_o     = {phase_q, ~phase_q};
                core_mul_row_sel_o   = phase_q;
                core_mul_en_o        = 1'b1;
                core_accumulate_en_o = {phase_q, 1'b1};
                data_o               = phase_q ? core_accumulate_i[15:8] : core_accumulate_i[7:0];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tiny_nn_conv_seq.sv
// Bench for tiny_nn_conv_seq: queue-of-expected-cycles model, per-cycle compare, directed literal checks and random traffic.
module tb_tiny_nn_conv_seq;
    import tiny_nn_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [15:0] data_i;
    logic [7:0]  data_o;
    fp_t         core_val_o;
    logic [1:0]  core_val_shift_o;
    fp_t         core_param_o;
    logic [7:0]  core_param_write_o;
    logic        core_mul_row_sel_o;
    logic        core_mul_en_o;
    logic [1:0]  core_accumulate_en_o;
    fp_t         core_accumulate_i;

    always #5 clk_i = ~clk_i;

    tiny_nn_conv_seq dut (
        .clk_i                (clk_i),
        .rst_ni               (rst_ni),
        .data_i               (data_i),
        .data_o               (data_o),
        .core_val_o           (core_val_o),
        .core_val_shift_o     (core_val_shift_o),
        .core_param_o         (core_param_o),
        .core_param_write_o   (core_param_write_o),
        .core_mul_row_sel_o   (core_mul_row_sel_o),
        .core_mul_en_o        (core_mul_en_o),
        .core_accumulate_en_o (core_accumulate_en_o),
        .core_accumulate_i    (core_accumulate_i)
    );

    localparam logic [1:0] KIN = 2'd0;  // fresh parameter from host
    localparam logic [1:0] KRP = 2'd1;  // replayed parameter
    localparam logic [1:0] KEX = 2'd2;  // exec cycle

    typedef struct packed {
        logic [1:0] kind;
        logic [2:0] k;
        logic       ph;
    } exp_t;

    exp_t mq [$];
    fp_t  m_cache [8];
    bit   m_valid;
    bit   chk_en;
    int   n_checks;
    int   n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_seq(input logic [1:0] kind, input int cnt);
        for (int k = 0; k < 8; k++) mq.push_back('{kind, 3'(k), 1'b0});
        for (int p = 0; p < 2 * (cnt + 1); p++) mq.push_back('{KEX, 3'd0, p[0]});
    endtask

    // Advance the model by one clock edge using the inputs the DUT sampled.
    task automatic model_step();
        exp_t e;
        if (!rst_ni) begin
            mq.delete();
            m_valid = 1'b0;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            if (e.kind == KIN) begin
                m_cache[e.k] = data_i;
                if (e.k == 3'd7) m_valid = 1'b1;
            end
        end else if (data_i[15:12] == 4'h1) begin
            m_valid = 1'b0;
            push_seq(KIN, int'(data_i[11:0]));
        end else if (data_i[15:12] == 4'h2 && m_valid) begin
            push_seq(KRP, int'(data_i[11:0]));
        end
    endtask

    task automatic compare_cycle();
        exp_t e;
        if (!chk_en) return;
        check("val", 32'(core_val_o), 32'(data_i));
        if (mq.size() == 0) begin
            check("idle_data_o", 32'(data_o), 32'hFF);
            check("idle_shift", 32'(core_val_shift_o), 32'h0);
            check("idle_pwrite", 32'(core_param_write_o), 32'h0);
            check("idle_rowsel", 32'(core_mul_row_sel_o), 32'h0);
            check("idle_mul_en", 32'(core_mul_en_o), 32'h0);
            check("idle_acc_en", 32'(core_accumulate_en_o), 32'h0);
        end else begin
            e = mq[0];
            if (e.kind == KEX) begin
                check("ex_shift", 32'(core_val_shift_o), e.ph ? 32'h2 : 32'h1);
                check("ex_rowsel", 32'(core_mul_row_sel_o), 32'(e.ph));
                check("ex_mul_en", 32'(core_mul_en_o), 32'h1);
                check("ex_acc_en", 32'(core_accumulate_en_o), e.ph ? 32'h3 : 32'h1);
                check("ex_data_o", 32'(data_o),
                      e.ph ? 32'(core_accumulate_i[15:8]) : 32'(core_accumulate_i[7:0]));
                check("ex_pwrite", 32'(core_param_write_o), 32'h0);
            end else begin
                check("p_pwrite", 32'(core_param_write_o), 32'h1 << e.k);
                check("p_param", 32'(core_param_o),
                      (e.kind == KIN) ? 32'(data_i) : 32'(m_cache[e.k]));
                check("p_data_o", 32'(data_o), 32'hFF);
                check("p_mul_en", 32'(core_mul_en_o), 32'h0);
                check("p_shift", 32'(core_val_shift_o), 32'h0);
            end
        end
    endtask

    task automatic sample();
        @(negedge clk_i);
        compare_cycle();
    endtask

    task automatic advance();
        @(posedge clk_i);
        model_step();
        #1;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        logic [3:0]  op;
        w  = 16'($urandom);
        op = 4'($urandom_range(0, 3));
        w[15:12] = op;
        if (op == 4'h1 || op == 4'h2) w[11:4] = 8'h0;
        return w;
    endfunction

    // Counts exec cycles starting at the current (first exec) cycle; ends sitting in the following idle cycle.
    task automatic count_exec(input int limit, input bit hot, output int n);
        n = 0;
        for (int c = 0; c < limit; c++) begin
            sample();
            if (!core_mul_en_o) break;
            n++;
            advance();
            core_accumulate_i = 16'($urandom);
            if (hot && n < 8000)
                data_i = (n % 64 == 0) ? {4'h1, 12'($urandom)} : 16'($urandom);
            else
                data_i = {4'h0, 12'($urandom)};
        end
        advance();
    endtask

    task automatic load_params(input logic [15:0] base, input bit rnd);
        for (int k = 0; k < 8; k++) begin
            data_i = rnd ? 16'($urandom) : base + 16'(k);
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        n_checks = 0;
        n_fail   = 0;
        chk_en   = 1'b0;
        m_valid  = 1'b0;
        rst_ni   = 1'b0;
        data_i   = 16'h0;
        core_accumulate_i = 16'h0;
        @(posedge clk_i);
        model_step();
        #1;
        chk_en = 1'b1;

        // Reset state
        repeat (2) begin
            sample();
            check("rst_data_o", 32'(data_o), 32'hFF);
            check("rst_strobes", 32'({core_val_shift_o, core_param_write_o, core_mul_en_o, core_accumulate_en_o}), 32'h0);
            advance();
        end
        rst_ni = 1'b1;

        // Cached command with no valid cache is ignored
        data_i = 16'h2000;
        tick();
        data_i = 16'h0;
        sample();
        check("cached_ign_data_o", 32'(data_o), 32'hFF);
        check("cached_ign_pwrite", 32'(core_param_write_o), 32'h0);
        advance();

        // Convolve count=0 with params 0x3C00..0x3C07
        data_i = 16'h1000;
        tick();
        for (int k = 0; k < 8; k++) begin
            data_i = 16'h3C00 + 16'(k);
            sample();
            check("conv_pwrite_lit", 32'(core_param_write_o), 32'h1 << k);
            advance();
        end
        data_i = 16'h0;
        count_exec(20, 1'b0, n);
        check("conv_exec_cycles", 32'(n), 32'd2);

        // Cached replay count=2 with garbage on data_i
        data_i = 16'h2002;
        tick();
        for (int k = 0; k < 8; k++) begin
            data_i = 16'($urandom);
            sample();
            check("replay_param_lit", 32'(core_param_o), 32'h3C00 + 32'(k));
            check("replay_pwrite_lit", 32'(core_param_write_o), 32'h1 << k);
            advance();
        end
        data_i = 16'h0;
        count_exec(40, 1'b0, n);
        check("replay_exec_cycles", 32'(n), 32'd6);

        // Accumulator byte selection
        core_accumulate_i = 16'hABCD;
        data_i = 16'h1000;
        tick();
        load_params(16'h0, 1'b1);
        data_i = 16'h0;
        sample();
        check("acc_lo_lit", 32'(data_o), 32'hCD);
        check("shift_ph0_lit", 32'(core_val_shift_o), 32'h1);
        advance();
        sample();
        check("acc_hi_lit", 32'(data_o), 32'hAB);
        check("shift_ph1_lit", 32'(core_val_shift_o), 32'h2);
        advance();
        sample();
        check("acc_done_lit", 32'(data_o), 32'hFF);
        advance();

        // Reset in the middle of a parameter load invalidates the cache
        data_i = 16'h1000;
        tick();
        for (int k = 0; k < 4; k++) begin
            data_i = 16'h5000 + 16'(k);
            tick();
        end
        rst_ni = 1'b0;
        data_i = 16'h5004;
        tick();
        rst_ni = 1'b1;
        data_i = 16'h2003;
        tick();
        data_i = 16'h0;
        repeat (12) begin
            sample();
            check("abort_pwrite_lit", 32'(core_param_write_o), 32'h0);
            check("abort_mul_en_lit", 32'(core_mul_en_o), 32'h0);
            advance();
        end

        // Maximum count, with convolve opcodes arriving as plain values during Exec
        data_i = 16'h1FFF;
        tick();
        load_params(16'h0, 1'b1);
        data_i = 16'h1005;
        count_exec(9000, 1'b1, n);
        check("max_exec_cycles", 32'(n), 32'd8192);

        // Random traffic with occasional resets
        repeat (800) begin
            rst_ni = ($urandom_range(0, 149) != 0);
            data_i = rand_word();
            core_accumulate_i = 16'($urandom);
            tick();
        end
        rst_ni = 1'b1;
        data_i = 16'h0;
        repeat (60) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
